// File: rtl/jtdsp16_fetch.sv
// jtdsp16_fetch: instruction register, decode and squash/interrupt sequencing ahead of the XAAU.
// Define JTDSP16_FETCH_IRQSYNC_EN to pass irq_req through a two-flop synchronizer.
module jtdsp16_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        cen,
   input  logic [15:0] rom_data,
   input  logic        irq_req,
   input  logic        halt,
   output logic        goto_ja,
   output logic        call_ja,
   output logic        goto_b,
   output logic        icall,
   output logic        imm_load,
   output logic        ram_load,
   output logic        post_inc,
   output logic        pc_halt,
   output logic        do_start,
   output logic [10:0] do_data,
   output logic [2:0]  r_field,
   output logic [11:0] i_field,
   output logic        ext_irq,
   output logic        shadow
);
   logic [15:0] ir;
   logic [4:0]  t;
   logic        ir_valid, valid, irq, flow, squash_next, ireturn;

`ifdef JTDSP16_FETCH_IRQSYNC_EN
   logic [1:0] irq_sync;
   always_ff @(posedge clk or posedge rst)
      if (rst) irq_sync <= '0;
      else if (cen) irq_sync <= {irq_sync[0], irq_req};
   assign irq = irq_sync[1];
`else
   assign irq = irq_req;
`endif

   assign t        = ir[15:11];
   assign valid    = ir_valid & ~halt;
   assign goto_ja  = valid & (ir[15:12] == 4'b0000);
   assign call_ja  = valid & (ir[15:12] == 4'b1000);
   assign goto_b   = valid & (t == 5'b11000);
   assign icall    = valid & (t == 5'b11100);
   assign imm_load = valid & (t == 5'b01010);
   assign ram_load = valid & (t == 5'b01011);
   assign post_inc = ram_load & ir[0];
   assign do_start = valid & (t == 5'b01110);
   assign pc_halt  = halt;
   assign do_data  = ir[10:0];
   assign r_field  = ir[6:4];
   assign i_field  = ir[11:0];
   assign ireturn  = goto_b & (ir[10:8] == 3'b001);
   assign flow     = goto_ja | call_ja | goto_b | icall | imm_load;
   // interrupts only enter on a plain instruction so the squashed word is a clean return point
   assign ext_irq     = irq & ~shadow & valid & ~flow & ~do_start;
   assign squash_next = flow | ext_irq;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ir       <= '0;
         ir_valid <= 1'b0;
         shadow   <= 1'b0;
      end else if (cen && !halt) begin
         ir       <= rom_data;
         ir_valid <= ~squash_next;
         if (ext_irq) shadow <= 1'b1;
         else if (ireturn && shadow) shadow <= 1'b0;
      end
endmodule

// File: tb/tb_jtdsp16_fetch.sv
// tb_jtdsp16_fetch: directed and random stimulus against a per-instruction behavioural model of the fetch stage.
module tb_jtdsp16_fetch;
   logic        clk = 0, rst = 0, cen = 0, irq_req = 0, halt = 0;
   logic [15:0] rom_data = '0;
   logic        goto_ja, call_ja, goto_b, icall, imm_load, ram_load, post_inc, pc_halt, do_start, ext_irq, shadow;
   logic [10:0] do_data;
   logic [2:0]  r_field;
   logic [11:0] i_field;
   int vectors = 0, miscompares = 0;

   logic [15:0] m_ir;
   logic        m_valid, m_shadow, m_s1, m_s2;

   jtdsp16_fetch dut (
      .clk(clk), .rst(rst), .cen(cen), .rom_data(rom_data), .irq_req(irq_req), .halt(halt),
      .goto_ja(goto_ja), .call_ja(call_ja), .goto_b(goto_b), .icall(icall), .imm_load(imm_load),
      .ram_load(ram_load), .post_inc(post_inc), .pc_halt(pc_halt), .do_start(do_start),
      .do_data(do_data), .r_field(r_field), .i_field(i_field), .ext_irq(ext_irq), .shadow(shadow)
   );

   always #5 clk = ~clk;

   // bit order: goto_ja call_ja goto_b icall imm_load ram_load post_inc pc_halt do_start ext_irq
   function automatic logic [9:0] model_out(input logic [15:0] w, input logic v, sh, h, rq);
      logic [9:0] o;
      o = '0;
      o[2] = h;
      if (v && !h) begin
         casez (w[15:11])
            5'b0000?: o[9] = 1'b1;
            5'b1000?: o[8] = 1'b1;
            5'b11000: o[7] = 1'b1;
            5'b11100: o[6] = 1'b1;
            5'b01010: o[5] = 1'b1;
            5'b01011: begin o[4] = 1'b1; o[3] = w[0]; end
            5'b01110: o[1] = 1'b1;
            default: ;
         endcase
         if (rq && !sh && o[9:5] == 5'b0 && !o[1]) o[0] = 1'b1;
      end
      return o;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset;
      m_ir = '0; m_valid = 0; m_shadow = 0; m_s1 = 0; m_s2 = 0;
   endtask

   task automatic check_outputs(input logic h, input logic rq);
      logic [9:0] e;
      e = model_out(m_ir, m_valid, m_shadow, h, rq);
      check("strobes", {goto_ja, call_ja, goto_b, icall, imm_load, ram_load, post_inc, pc_halt, do_start, ext_irq}, e);
      check("fields", {i_field, do_data, r_field}, {m_ir[11:0], m_ir[10:0], m_ir[6:4]});
      check("shadow", shadow, m_shadow);
   endtask

   task automatic step(input logic [15:0] w, input logic c, input logic h, input logic q);
      logic [9:0] e;
      logic       rq;
      rom_data = w; cen = c; halt = h; irq_req = q;
`ifdef JTDSP16_FETCH_IRQSYNC_EN
      rq = m_s2;
`else
      rq = q;
`endif
      @(negedge clk);
      check_outputs(h, rq);
      e = model_out(m_ir, m_valid, m_shadow, h, rq);
      @(posedge clk);
      if (c) begin
         m_s2 = m_s1; m_s1 = q;
         if (!h) begin
            // a taken branch, immediate load or interrupt entry kills the word already fetched
            m_valid = !(e[9:5] != 0 || e[0]);
            if (e[0]) m_shadow = 1;
            else if (e[7] && m_ir[10:8] == 3'b001) m_shadow = 0;
            m_ir = w;
         end
      end
      #1;
   endtask

   task automatic do_reset;
      cen = 0; rst = 1;
      model_reset();
      @(negedge clk);
      check_outputs(halt, 1'b0);
      rst = 0;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_word;
      logic [15:0] r;
      r = 16'($urandom);
      case ($urandom_range(0, 8))
         0: return {4'b0000, r[11:0]};
         1: return {4'b1000, r[11:0]};
         2: return {5'b11000, r[0] ? 3'b001 : r[10:8], r[7:0]};
         3: return {5'b11100, r[10:0]};
         4: return {5'b01010, r[10:0]};
         5: return {5'b01011, r[10:0]};
         6: return {5'b01110, r[10:0]};
         default: return r;
      endcase
   endfunction

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset();
      step(16'h5000, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      step(16'h0123, 1, 0, 0);
      step(16'h0456, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      step(16'h5020, 1, 0, 0);
      step(16'hBEEF, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      repeat (6) step(16'h5000, 1, 0, 1);
      step(16'hC100, 1, 0, 1);
      step(16'h5000, 1, 0, 1);
      repeat (3) step(16'h5000, 1, 0, 0);
      step(16'hC100, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      step(16'h0123, 1, 0, 0);
      step(16'h0456, 1, 0, 0);
      repeat (3) step(16'h0456, 1, 1, 0);
      step(16'h0456, 1, 0, 0);
      step(16'h5000, 1, 0, 0);
      repeat (2) step(16'h1234, 0, 0, 0);
      step(16'h5000, 1, 0, 0);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 96) == 0) do_reset();
         step(rand_word(), $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
